// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, fetches one word, holds it for decode.
// Optional performance counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic        bad_target;
  logic        accept;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign accept    = (state == S_HOLD) && instr_ready;

  // JALR clears bit 0 before the alignment check, so only bit 1 can fault it.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc + imm_ext;
      2'b10: next_pc = {alu_result[31:1], 1'b0};
      2'b11: next_pc = pc;
    endcase
    bad_target = (next_pc[1:0] != 2'b00) || (pc_src == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = bad_target ? S_FAULT : S_FETCH;
      end
      S_FAULT: fetch_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      if ((state == S_FETCH) && imem_rvalid) instr <= imem_rdata;
      if (accept && !bad_target)             pc    <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (accept && !bad_target) fetch_cnt <= fetch_cnt + 32'd1;
      if (((state == S_FETCH) && !imem_rvalid) || ((state == S_HOLD) && !instr_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: modelled IMEM with programmable wait states.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int delay = 0;
  int wait_cnt = 0;
  bit sb_en = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .pc_src(pc_src), .imm_ext(imm_ext), .alu_result(alu_result),
    .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0013;
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rvalid = imem_req && (wait_cnt >= delay);

  always @(posedge clk)
    wait_cnt <= (imem_req && !imem_rvalid) ? wait_cnt + 1 : 0;

  // Scoreboard: fetch handshakes consume expected addresses, accepts consume expected words.
  always @(negedge clk) begin
    if (sb_en) begin
      if (imem_req && imem_rvalid) begin
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_fail++;
          $display("FAIL sb_fetch_unexpected: got addr %h want no fetch", imem_addr);
        end else begin
          logic [31:0] a;
          a = exp_addr.pop_front();
          exp_instr.push_back(mem_word(a));
          if (imem_addr !== a) begin
            n_fail++;
            $display("FAIL sb_fetch_addr: got %h want %h", imem_addr, a);
          end
        end
      end
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (exp_instr.size() == 0) begin
          n_fail++;
          $display("FAIL sb_accept_unexpected: got instr %h want no accept", instr);
        end else begin
          logic [31:0] w;
          w = exp_instr.pop_front();
          if (instr !== w) begin
            n_fail++;
            $display("FAIL sb_instr: got %h want %h", instr, w);
          end
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    exp_addr.delete();
    exp_instr.delete();
    reset = 1'b1;
    repeat (2) nxt();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      nxt();
    end
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: got instr_valid %b want 1", name, instr_valid);
    end
  endtask

  task automatic test_reset();
    delay = 0; instr_ready = 1'b0; pc_src = 2'b00;
    reset = 1'b1;
    repeat (2) nxt();
    n_cmp++;
    if ({imem_req, instr_valid, fetch_fault} !== 3'b000 || pc !== 32'd0 || instr !== 32'h13) begin
      n_fail++;
      $display("FAIL reset_state: got req/vld/flt %b%b%b pc %h instr %h want 000 0 00000013",
               imem_req, instr_valid, fetch_fault, pc, instr);
    end
    reset = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_req: got %b want 0", imem_req);
    end
    nxt();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL first_fetch: got req %b addr %h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    int last;
    delay = 0; instr_ready = 1'b1; pc_src = 2'b00;
    do_reset();
    for (int k = 0; k < 5; k++) exp_addr.push_back(32'(k * 4));
    sb_en = 1'b1;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      nxt();
      if (imem_req && imem_rvalid) begin
        if (last >= 0) begin
          n_cmp++;
          if (c - last !== 2) begin
            n_fail++; $display("FAIL fetch_spacing: got %0d want 2", c - last);
          end
        end
        last = c;
      end
      if (exp_addr.size() == 0 && exp_instr.size() == 0) break;
    end
    sb_en = 1'b0;
    instr_ready = 1'b0;
    n_cmp++;
    if (exp_addr.size() + exp_instr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_wait_drain: got %0d pending want 0", exp_addr.size() + exp_instr.size());
    end
  endtask

  task automatic test_wait_states();
    int req_cnt, rv_cyc, vld_cyc;
    delay = 3; instr_ready = 1'b0; pc_src = 2'b00;
    do_reset();
    req_cnt = 0; rv_cyc = -10; vld_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      if (imem_req && imem_addr === 32'd0) req_cnt++;
      if (imem_rvalid) rv_cyc = i;
      if (instr_valid) begin vld_cyc = i; break; end
    end
    n_cmp++;
    if (req_cnt !== 4) begin
      n_fail++; $display("FAIL wait_req_cycles: got %0d want 4", req_cnt);
    end
    n_cmp++;
    if (vld_cyc !== rv_cyc + 1) begin
      n_fail++; $display("FAIL wait_valid_timing: got %0d want %0d", vld_cyc, rv_cyc + 1);
    end
    n_cmp++;
    if (instr !== mem_word(32'd0)) begin
      n_fail++; $display("FAIL wait_instr: got %h want %h", instr, mem_word(32'd0));
    end
    // Stalled decode: word and PC must not move.
    for (int i = 0; i < 5; i++) begin
      nxt();
      n_cmp++;
      if (instr !== mem_word(32'd0) || pc !== 32'd0 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: got instr %h pc %h vld %b req %b want %h 0 1 0",
                 instr, pc, instr_valid, imem_req, mem_word(32'd0));
      end
    end
    delay = 0; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
      n_fail++; $display("FAIL hold_release: got req %b addr %h want 1 4", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    delay = 0; instr_ready = 1'b0;
    do_reset();
    wait_valid("branch_a");
    pc_src = 2'b01; imm_ext = 32'h0000_0100; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    wait_valid("branch_b");
    n_cmp++;
    if (pc !== 32'h100) begin
      n_fail++; $display("FAIL branch_pc: got %h want 00000100", pc);
    end
    imm_ext = 32'hFFFF_FFF0; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0F0) begin
      n_fail++; $display("FAIL branch_back: got req %b addr %h want 1 000000f0", imem_req, imem_addr);
    end
    wait_valid("branch_c");
    imm_ext = 32'h0000_0006; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (fetch_fault !== 1'b1 || pc !== 32'h0F0) begin
      n_fail++; $display("FAIL branch_misalign: got fault %b pc %h want 1 000000f0", fetch_fault, pc);
    end
  endtask

  task automatic test_jalr();
    delay = 0; instr_ready = 1'b0;
    do_reset();
    wait_valid("jalr_a");
    pc_src = 2'b10; alu_result = 32'h0000_0201; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_clear_bit0: got req %b addr %h fault %b want 1 00000200 0",
               imem_req, imem_addr, fetch_fault);
    end
    wait_valid("jalr_b");
    alu_result = 32'h0000_0203; instr_ready = 1'b1;
    nxt();
    for (int i = 0; i < 4; i++) begin
      instr_ready = i[0];
      n_cmp++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h200) begin
        n_fail++;
        $display("FAIL jalr_fault_sticky: got flt %b req %b vld %b pc %h want 1 0 0 00000200",
                 fetch_fault, imem_req, instr_valid, pc);
      end
      nxt();
    end
    do_reset();
    n_cmp++;
    if (fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_cleared: got %b want 0", fetch_fault);
    end
    wait_valid("illegal_sel");
    pc_src = 2'b11; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (fetch_fault !== 1'b1) begin
      n_fail++; $display("FAIL illegal_select: got %b want 1", fetch_fault);
    end
  endtask

  task automatic test_reset_mid_fetch();
    delay = 0; instr_ready = 1'b0;
    do_reset();
    wait_valid("midrst");
    pc_src = 2'b01; imm_ext = 32'h100; instr_ready = 1'b1; delay = 10;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL midrst_fetching: got req %b addr %h want 1 00000100", imem_req, imem_addr);
    end
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0 || pc !== 32'd0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: got req %b pc %h vld %b want 0 0 0", imem_req, pc, instr_valid);
    end
  endtask

  task automatic test_wrap();
    delay = 0; instr_ready = 1'b0;
    do_reset();
    wait_valid("wrap");
    pc_src = 2'b01; imm_ext = 32'hFFFF_FFFC; instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0; pc_src = 2'b00;
    nxt();
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin
      n_fail++; $display("FAIL wrap_pc_plus4: got pc %h pc4 %h want fffffffc 0", pc, pc_plus4);
    end
    repeat (2) nxt();
    instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL wrap_fetch: got req %b addr %h flt %b want 1 0 0", imem_req, imem_addr, fetch_fault);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (fetch_cnt !== 32'd2 || stall_cnt !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts: got fetch %0d stall %0d want 2 2", fetch_cnt, stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jalr();
    test_reset_mid_fetch();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
